// File: rtl/sn_batch_ctrl.sv
// Batch controller for the odd-even merge sorting network: packs records into 2^P_LOG-lane
// batches, issues them under output-buffer credit, and drains sorted batches as a record stream.
module sn_batch_ctrl #(
    parameter int unsigned P_LOG     = 1,
    parameter int unsigned DATW      = 64,
    parameter int unsigned KEYW      = 32,
    parameter int unsigned OFIFO_LOG = 2
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [DATW-1:0]              IDATA,
    input  logic                         IVALID,
    output logic                         IREADY,
    input  logic                         IFLUSH,
    output logic [DATW*(1<<P_LOG)-1:0]   SN_DIN,
    output logic                         SN_DINEN,
    input  logic [DATW*(1<<P_LOG)-1:0]   SN_DOT,
    input  logic                         SN_DOTEN,
    output logic [DATW-1:0]              ODATA,
    output logic                         OVALID,
    input  logic                         OREADY,
    output logic                         OLAST,
    output logic                         BUSY,
    output logic                         ERR
);

    localparam int unsigned N = 1 << P_LOG;
    localparam int unsigned C = 1 << OFIFO_LOG;
    localparam logic [P_LOG:0]     CNT_FULL = (P_LOG + 1)'(N);
    localparam logic [OFIFO_LOG:0] CRED_MAX = (OFIFO_LOG + 1)'(C);

    // Assembler state
    logic [N-1:0][DATW-1:0] r_lane;
    logic [P_LOG:0]         r_cnt;
    logic                   r_flush_pend;
    logic [OFIFO_LOG:0]     r_credit;

    // Output buffer: sorted batches plus their real-record counts, popped together
    logic [N-1:0][DATW-1:0] r_bbuf [C];
    logic [P_LOG:0]         r_nbuf [C];
    logic [OFIFO_LOG:0]     r_bwr;
    logic [OFIFO_LOG:0]     r_brd;
    logic [OFIFO_LOG:0]     r_nwr;
    logic [OFIFO_LOG:0]     r_nrd;
    logic [P_LOG-1:0]       r_rsel;
    logic                   r_err;

    logic                   w_accept;
    logic                   w_issue;
    logic                   w_bempty;
    logic                   w_bfull;
    logic                   w_ovalid;
    logic                   w_olast;
    logic                   w_xfer;
    logic                   w_drain;
    logic [N-1:0][DATW-1:0] w_head;
    logic [P_LOG:0]         w_nhead;
    logic [DATW-1:0]        w_head_lane;
    logic [DATW-1:0]        w_odata;
    logic [N-1:0][DATW-1:0] w_din;

    assign IREADY   = !RST && (r_cnt < CNT_FULL) && !r_flush_pend;
    assign w_accept = IREADY && IVALID;
    assign w_issue  = !RST && ((r_cnt == CNT_FULL) || r_flush_pend) && (r_credit != '0);

    assign w_bempty = (r_bwr == r_brd);
    assign w_bfull  = (r_bwr[OFIFO_LOG] != r_brd[OFIFO_LOG]) &&
                      (r_bwr[OFIFO_LOG-1:0] == r_brd[OFIFO_LOG-1:0]);
    assign w_ovalid = !RST && !w_bempty;

    assign w_head      = r_bbuf[r_brd[OFIFO_LOG-1:0]];
    assign w_nhead     = r_nbuf[r_nrd[OFIFO_LOG-1:0]];
    assign w_head_lane = w_head[r_rsel];
    assign w_olast     = w_ovalid && ({1'b0, r_rsel} == (w_nhead - 1'b1));
    assign w_xfer      = w_ovalid && OREADY;
    assign w_drain     = w_xfer && w_olast;

    // The key sits in the low KEYW bits; the payload above it passes through untouched.
    if (KEYW < DATW) begin : g_keyed
        assign w_odata = {w_head_lane[DATW-1:KEYW], w_head_lane[KEYW-1:0]};
    end else begin : g_key_only
        assign w_odata = w_head_lane;
    end

    // Lanes beyond the real count are padded with all-ones so they sort to the top.
    always_comb begin
        w_din = '0;
        if (w_issue) begin
            for (int unsigned i = 0; i < N; i++) begin
                w_din[i] = ((P_LOG + 1)'(i) < r_cnt) ? r_lane[i] : '1;
            end
        end
    end

    assign SN_DIN   = w_din;
    assign SN_DINEN = w_issue;
    assign OVALID   = w_ovalid;
    assign ODATA    = w_ovalid ? w_odata : '0;
    assign OLAST    = w_olast;
    assign BUSY     = !RST && ((r_cnt != '0) || (r_credit != CRED_MAX));
    assign ERR      = !RST && r_err;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
            r_credit     <= CRED_MAX;
            r_bwr        <= '0;
            r_brd        <= '0;
            r_nwr        <= '0;
            r_nrd        <= '0;
            r_rsel       <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_issue) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_issue) begin
                r_flush_pend <= 1'b0;
            end else if (IFLUSH && ((r_cnt != '0) || w_accept)) begin
                r_flush_pend <= 1'b1;
            end

            if (w_issue && !w_drain) begin
                r_credit <= r_credit - 1'b1;
            end else if (w_drain && !w_issue) begin
                r_credit <= r_credit + 1'b1;
            end

            if (w_issue) begin
                r_nwr <= r_nwr + 1'b1;
            end

            if (SN_DOTEN) begin
                if (w_bfull) begin
                    r_err <= 1'b1;
                end else begin
                    r_bwr <= r_bwr + 1'b1;
                end
            end

            if (w_xfer) begin
                if (w_olast) begin
                    r_rsel <= '0;
                    r_brd  <= r_brd + 1'b1;
                    r_nrd  <= r_nrd + 1'b1;
                end else begin
                    r_rsel <= r_rsel + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_lane[r_cnt[P_LOG-1:0]] <= IDATA;
        end
        if (w_issue) begin
            r_nbuf[r_nwr[OFIFO_LOG-1:0]] <= r_cnt;
        end
        if (!RST && SN_DOTEN && !w_bfull) begin
            r_bbuf[r_bwr[OFIFO_LOG-1:0]] <= SN_DOT;
        end
    end

endmodule
